// File: rtl/calc1_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// calc1_arbiter
//
// Four-port calculator front end sharing one pipelined ALU. Each port runs a
// small FSM (IDLE -> OP2 -> WAIT -> BUSY). It collects a command and two
// operands over two cycles, waits for a grant, and then waits for its tagged
// result to leave the ALU pipeline.
//
// Parameters
//   ALU_STAGES      number of register stages in the shared ALU (1..3)
//
// Ports
//   c_clk           clock, all state updates on the rising edge
//   reset           asynchronous, active-high reset
//   reqN_cmd_in     port N command (0 no-op, 1 add, 2 sub, 5 shl, 6 shr)
//   reqN_data_in    port N operand bus (op1 in cmd cycle, op2 in next cycle)
//   out_dataN       port N result, zero outside a response cycle
//   out_respN       port N response (0 none, 1 success, 2 error)
//
// Build option
//   CALC1_ARB_FIXED_PRIO_EN   when defined, arbitration is fixed priority
//                             (port 1 highest) and the round-robin pointer
//                             is not built. The default is round-robin.
// -----------------------------------------------------------------------------
module calc1_arbiter #(
  parameter int ALU_STAGES = 1
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp4
);

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OP2,
    ST_WAIT,
    ST_BUSY
  } state_e;

  // One ALU pipeline slot: the result plus the tag of the port it belongs to.
  typedef struct packed {
    logic        vld;
    logic [1:0]  tag;
    logic [1:0]  resp;
    logic [31:0] data;
  } alu_stage_t;

  // Port buses gathered into arrays. Bit 0 of the external buses is the MSB,
  // so the values map directly onto conventional [31:0] numbers.
  logic [3:0]  cmd_in  [4];
  logic [31:0] data_in [4];

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  // Per-port FSM state and latched operands.
  state_e      state_q [4];
  state_e      state_d [4];
  logic [3:0]  cmd_q   [4];
  logic [3:0]  cmd_d   [4];
  logic [31:0] op1_q   [4];
  logic [31:0] op1_d   [4];
  logic [31:0] op2_q   [4];
  logic [31:0] op2_d   [4];

  // Arbitration result for this cycle.
  logic       gnt_vld;
  logic [1:0] gnt_idx;

  // ALU pipeline.
  alu_stage_t  pipe_q [ALU_STAGES];
  alu_stage_t  stage1_d;
  alu_stage_t  tail;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [32:0] alu_sum;

  // rsp_hit[i]: the result leaving the pipeline this cycle belongs to port i.
  logic [3:0]  rsp_hit;
  logic [31:0] data_o [4];
  logic [1:0]  resp_o [4];

  // ---------------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------------
`ifdef CALC1_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    // Walk from lowest priority up so the highest-priority WAIT port wins.
    for (int i = 3; i >= 0; i--) begin
      if (state_q[i] == ST_WAIT) begin
        gnt_vld = 1'b1;
        gnt_idx = 2'(i);
      end
    end
  end
`else
  logic [1:0] rr_last_q;
  logic [1:0] cand;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand    = rr_last_q;
    // Search starts one past the last grant; 2-bit arithmetic wraps 4 -> 1.
    for (int k = 1; k <= 4; k++) begin
      cand = rr_last_q + 2'(k);
      if (!gnt_vld && state_q[cand] == ST_WAIT) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      rr_last_q <= 2'd3;  // last grant "port 4" so port 1 is searched first
    end else if (gnt_vld) begin
      rr_last_q <= gnt_idx;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // ALU stage 1: computes the granted port's operation
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_cmd  = cmd_q[gnt_idx];
    alu_a    = op1_q[gnt_idx];
    alu_b    = op2_q[gnt_idx];
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
    stage1_d = '0;
    if (gnt_vld) begin
      stage1_d.vld  = 1'b1;
      stage1_d.tag  = gnt_idx;
      stage1_d.resp = RESP_ERR;  // errors always return data 0
      case (alu_cmd)
        CMD_ADD: begin
          if (!alu_sum[32]) begin
            stage1_d.resp = RESP_OK;
            stage1_d.data = alu_sum[31:0];
          end
        end
        CMD_SUB: begin
          if (alu_b <= alu_a) begin
            stage1_d.resp = RESP_OK;
            stage1_d.data = alu_a - alu_b;
          end
        end
        CMD_SHL: begin
          stage1_d.resp = RESP_OK;
          stage1_d.data = alu_a << alu_b[4:0];
        end
        CMD_SHR: begin
          stage1_d.resp = RESP_OK;
          stage1_d.data = alu_a >> alu_b[4:0];
        end
        default: ;  // invalid command: error, data 0
      endcase
    end
  end

  // NOTE: the pipeline registers are reset because their valid bits must not
  // come out of reset as phantom results; reset also discards in-flight work.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < ALU_STAGES; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      pipe_q[0] <= stage1_d;
      for (int s = 1; s < ALU_STAGES; s++) begin
        pipe_q[s] <= pipe_q[s-1];
      end
    end
  end

  assign tail = pipe_q[ALU_STAGES-1];

  // ---------------------------------------------------------------------------
  // Per-port FSMs
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rsp_hit[i] = tail.vld && (tail.tag == 2'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cmd_d[i]   = cmd_q[i];
      op1_d[i]   = op1_q[i];
      op2_d[i]   = op2_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (cmd_in[i] != 4'd0) begin
            state_d[i] = ST_OP2;
            cmd_d[i]   = cmd_in[i];
            op1_d[i]   = data_in[i];
          end
        end
        ST_OP2: begin
          state_d[i] = ST_WAIT;
          op2_d[i]   = data_in[i];
        end
        ST_WAIT: begin
          if (gnt_vld && gnt_idx == 2'(i)) begin
            state_d[i] = ST_BUSY;
          end
        end
        ST_BUSY: begin
          // The response cycle doubles as an IDLE cycle for a new command.
          if (rsp_hit[i]) begin
            if (cmd_in[i] != 4'd0) begin
              state_d[i] = ST_OP2;
              cmd_d[i]   = cmd_in[i];
              op1_d[i]   = data_in[i];
            end else begin
              state_d[i] = ST_IDLE;
            end
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_IDLE;
        cmd_q[i]   <= '0;
        op1_q[i]   <= '0;
        op2_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cmd_q[i]   <= cmd_d[i];
        op1_q[i]   <= op1_d[i];
        op2_q[i]   <= op2_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: only the port owning the pipeline tail sees a non-zero response
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      resp_o[i] = rsp_hit[i] ? tail.resp : 2'd0;
      data_o[i] = rsp_hit[i] ? tail.data : 32'd0;
    end
  end

  assign out_resp1 = resp_o[0];
  assign out_resp2 = resp_o[1];
  assign out_resp3 = resp_o[2];
  assign out_resp4 = resp_o[3];
  assign out_data1 = data_o[0];
  assign out_data2 = data_o[1];
  assign out_data3 = data_o[2];
  assign out_data4 = data_o[3];

endmodule

// File: tb/tb_calc1_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_calc1_arbiter
//
// Self-checking bench for calc1_arbiter. Directed scenarios cover reset,
// arithmetic corner cases, shifts, arbitration order and reset during an
// in-flight operation. A randomized phase compares every port, every cycle,
// against a transaction-level model. Inputs are driven and outputs sampled
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_calc1_arbiter;

  localparam int ALU_STAGES = 1;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cmd_a  [4];
  logic [31:0] data_a [4];
  logic [31:0] odata  [4];
  logic [1:0]  oresp  [4];

  logic [31:0] out_data1, out_data2, out_data3, out_data4;
  logic [1:0]  out_resp1, out_resp2, out_resp3, out_resp4;

  int errors = 0;
  int checks = 0;

  calc1_arbiter #(.ALU_STAGES(ALU_STAGES)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd_a[0]),
    .req1_data_in (data_a[0]),
    .req2_cmd_in  (cmd_a[1]),
    .req2_data_in (data_a[1]),
    .req3_cmd_in  (cmd_a[2]),
    .req3_data_in (data_a[2]),
    .req4_cmd_in  (cmd_a[3]),
    .req4_data_in (data_a[3]),
    .out_data1    (out_data1),
    .out_resp1    (out_resp1),
    .out_data2    (out_data2),
    .out_resp2    (out_resp2),
    .out_data3    (out_data3),
    .out_resp3    (out_resp3),
    .out_data4    (out_data4),
    .out_resp4    (out_resp4)
  );

  assign odata[0] = out_data1;
  assign odata[1] = out_data2;
  assign odata[2] = out_data3;
  assign odata[3] = out_data4;
  assign oresp[0] = out_resp1;
  assign oresp[1] = out_resp2;
  assign oresp[2] = out_resp3;
  assign oresp[3] = out_resp4;

  always #5 c_clk = ~c_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  // Reference arithmetic: {resp, data} for one operation.
  function automatic void golden(input logic [3:0] cmd, input logic [31:0] a,
                                 input logic [31:0] b, output logic [1:0] r,
                                 output logic [31:0] d);
    logic [63:0] wide;
    r = 2'd2;
    d = 32'd0;
    case (cmd)
      4'd1: begin
        wide = {32'd0, a} + {32'd0, b};
        if (wide <= 64'h0000_0000_FFFF_FFFF) begin r = 2'd1; d = wide[31:0]; end
      end
      4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
      4'd5: begin r = 2'd1; d = a << (b % 32); end
      4'd6: begin r = 2'd1; d = a >> (b % 32); end
      default: ;
    endcase
  endfunction

  task automatic idle_inputs();
    for (int p = 0; p < 4; p++) begin
      cmd_a[p]  = 4'd0;
      data_a[p] = 32'd0;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge c_clk);
    reset = 1'b0;
    @(negedge c_clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    for (int p = 0; p < 4; p++) begin
      cmd_a[p]  = 4'd1;
      data_a[p] = $urandom;
    end
    repeat (3) begin
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (oresp[p] !== 2'd0 || odata[p] !== 32'd0) begin
          errors++;
          $display("FAIL reset_hold port%0d: got resp=%0d data=%08h, want 0/0", p + 1, oresp[p], odata[p]);
        end
      end
    end
    idle_inputs();
    reset = 1'b0;
    repeat (4) begin
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (oresp[p] !== 2'd0 || odata[p] !== 32'd0) begin
          errors++;
          $display("FAIL reset_release port%0d: got resp=%0d data=%08h, want 0/0", p + 1, oresp[p], odata[p]);
        end
      end
    end
  endtask

  // One operation on one port with all other ports quiet. Junk commands in
  // the OP2 and WAIT cycles must be ignored.
  task automatic test_single_op(input string name, input int port, input logic [3:0] cmd,
                                input logic [31:0] op1, input logic [31:0] op2,
                                input logic [1:0] exp_r, input logic [31:0] exp_d);
    logic [1:0]  er [4];
    logic [31:0] ed [4];
    idle_inputs();
    cmd_a[port]  = cmd;
    data_a[port] = op1;
    @(negedge c_clk);
    cmd_a[port]  = 4'd1;
    data_a[port] = op2;
    @(negedge c_clk);
    for (int c = 2; c <= ALU_STAGES + 5; c++) begin
      cmd_a[port]  = (c == 2) ? 4'd6 : 4'd0;
      data_a[port] = (c == 2) ? $urandom : 32'd0;
      for (int p = 0; p < 4; p++) begin
        er[p] = (p == port && c == 2 + ALU_STAGES) ? exp_r : 2'd0;
        ed[p] = (p == port && c == 2 + ALU_STAGES) ? exp_d : 32'd0;
        checks++;
        if (oresp[p] !== er[p] || odata[p] !== ed[p]) begin
          errors++;
          $display("FAIL %s port%0d cycle T+%0d: got resp=%0d data=%08h, want resp=%0d data=%08h",
                   name, p + 1, c, oresp[p], odata[p], er[p], ed[p]);
        end
      end
      @(negedge c_clk);
    end
  endtask

  task automatic test_arith();
    test_single_op("add_basic", 0, 4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000);
    test_single_op("add_ovf",   1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'd0);
    test_single_op("add_max",   1, 4'd1, 32'hFFFF_FFFE, 32'h0000_0001, 2'd1, 32'hFFFF_FFFF);
    test_single_op("sub_under", 2, 4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'd0);
    test_single_op("sub_equal", 2, 4'd2, 32'h1234_5678, 32'h1234_5678, 2'd1, 32'd0);
    test_single_op("sub_basic", 0, 4'd2, 32'h0000_0100, 32'h0000_0001, 2'd1, 32'h0000_00FF);
    test_single_op("invalid3",  3, 4'd3, 32'h0000_0005, 32'h0000_0006, 2'd2, 32'd0);
    test_single_op("invalid15", 3, 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 32'd0);
  endtask

  task automatic test_shifts();
    logic [31:0] amt;
    for (int s = 0; s < 32; s++) begin
      amt = {$urandom_range(0, 32'h07FF_FFFF), 5'(s)};  // upper bits must be ignored
      test_single_op("shl", s % 4, 4'd5, 32'h0000_0001, amt, 2'd1, 32'd1 << s);
      test_single_op("shr", (s + 1) % 4, 4'd6, 32'h8000_0000, amt, 2'd1, 32'h8000_0000 >> s);
    end
    test_single_op("shl_amt21", 1, 4'd5, 32'h0000_0001, 32'h0000_0021, 2'd1, 32'h0000_0002);
  endtask

  // All four ports issue together; responses must come out one per cycle
  // starting with port `first` and continuing in wrap-around order.
  task automatic test_burst(input string name, input int first);
    logic [1:0]  er [4];
    logic [31:0] ed [4];
    int          slot;
    for (int p = 0; p < 4; p++) begin
      cmd_a[p]  = 4'd1;
      data_a[p] = 32'(p + 1);
    end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin
      cmd_a[p]  = 4'd0;
      data_a[p] = 32'd10;
    end
    @(negedge c_clk);
    idle_inputs();
    for (int c = 2; c <= ALU_STAGES + 7; c++) begin
      for (int p = 0; p < 4; p++) begin
        slot  = (p - first + 4) % 4;
        er[p] = (c == 2 + ALU_STAGES + slot) ? 2'd1 : 2'd0;
        ed[p] = (c == 2 + ALU_STAGES + slot) ? 32'(p + 11) : 32'd0;
        checks++;
        if (oresp[p] !== er[p] || odata[p] !== ed[p]) begin
          errors++;
          $display("FAIL %s port%0d cycle T+%0d: got resp=%0d data=%08h, want resp=%0d data=%08h",
                   name, p + 1, c, oresp[p], odata[p], er[p], ed[p]);
        end
      end
      @(negedge c_clk);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    test_burst("burst_first", 0);
    test_burst("burst_again", 0);
    test_single_op("port3_alone", 2, 4'd1, 32'd1, 32'd1, 2'd1, 32'd2);
`ifdef CALC1_ARB_FIXED_PRIO_EN
    test_burst("burst_after_p3", 0);
`else
    test_burst("burst_after_p3", 3);
`endif
  endtask

`ifdef CALC1_ARB_FIXED_PRIO_EN
  // Port 1 re-issues in its response cycle while port 4 waits. Port 1 was
  // granted last, so only fixed priority lets port 1 win the first contest.
  task automatic test_fixed_prio();
    logic [1:0]  er [4];
    logic [31:0] ed [4];
    test_single_op("prio_warmup", 0, 4'd1, 32'd1, 32'd1, 2'd1, 32'd2);
    for (int c = 0; c <= 2 * ALU_STAGES + 6; c++) begin
      for (int p = 0; p < 4; p++) begin
        er[p] = 2'd0;
        ed[p] = 32'd0;
      end
      if (c == 2 + ALU_STAGES)     begin er[0] = 2'd1; ed[0] = 32'd2; end
      if (c == 4 + 2 * ALU_STAGES) begin er[0] = 2'd1; ed[0] = 32'd4; end
      if (c == 3 + ALU_STAGES)     begin er[3] = 2'd1; ed[3] = 32'd5; end
      if (c >= 2) begin
        for (int p = 0; p < 4; p++) begin
          checks++;
          if (oresp[p] !== er[p] || odata[p] !== ed[p]) begin
            errors++;
            $display("FAIL fixed_prio port%0d cycle T+%0d: got resp=%0d data=%08h, want resp=%0d data=%08h",
                     p + 1, c, oresp[p], odata[p], er[p], ed[p]);
          end
        end
      end
      idle_inputs();
      if (c == 0) begin cmd_a[0] = 4'd1; data_a[0] = 32'd1; cmd_a[3] = 4'd1; data_a[3] = 32'd4; end
      if (c == 1) begin data_a[0] = 32'd1; data_a[3] = 32'd1; end
      if (c == 2 + ALU_STAGES) begin cmd_a[0] = 4'd1; data_a[0] = 32'd2; end
      if (c == 3 + ALU_STAGES) data_a[0] = 32'd2;
      @(negedge c_clk);
    end
  endtask
`endif

  // Reset lands right after port 2 is granted while port 1 is mid-collection;
  // neither operation may ever respond.
  task automatic test_reset_inflight();
    idle_inputs();
    cmd_a[1]  = 4'd1;
    data_a[1] = 32'd7;
    @(negedge c_clk);
    cmd_a[1]  = 4'd0;
    data_a[1] = 32'd9;
    cmd_a[0]  = 4'd1;
    data_a[0] = 32'd1;
    @(negedge c_clk);
    idle_inputs();
    data_a[0] = 32'd1;
    @(posedge c_clk);  // port 2 grant edge
    #1 reset = 1'b1;
    idle_inputs();
    for (int c = 0; c < 9; c++) begin
      if (c == 2) reset = 1'b0;
      #1;
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (oresp[p] !== 2'd0 || odata[p] !== 32'd0) begin
          errors++;
          $display("FAIL reset_inflight port%0d step %0d: got resp=%0d data=%08h, want 0/0",
                   p + 1, c, oresp[p], odata[p]);
        end
      end
      @(negedge c_clk);
    end
    test_single_op("post_reset_add", 1, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5);
  endtask

  // ---------------------------------------------------------------------------
  // Randomized traffic against a transaction-level model: each port holds at
  // most one operation, tracked by the cycle its command was seen, whether it
  // has been granted, and the cycle its response is due.
  // ---------------------------------------------------------------------------
  task automatic test_random();
    logic [3:0]  cmd_tab [12] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2, 4'd5, 4'd6,
                                  4'd3, 4'd4, 4'd7, 4'd15};
    bit          m_act [4];
    bit          m_gnt [4];
    int          m_cap [4];
    int          m_due [4];
    logic [3:0]  m_cmd [4];
    logic [31:0] m_op1 [4];
    logic [31:0] m_op2 [4];
    int          m_last;
    int          winner;
    int          cand;
    logic [1:0]  er;
    logic [31:0] ed;

    apply_reset();
    m_last = 3;
    for (int p = 0; p < 4; p++) begin
      m_act[p] = 1'b0;
      m_gnt[p] = 1'b0;
      m_cap[p] = 0;
      m_due[p] = 0;
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < 4; p++) begin
        er = 2'd0;
        ed = 32'd0;
        if (m_act[p] && m_gnt[p] && m_due[p] == cyc) golden(m_cmd[p], m_op1[p], m_op2[p], er, ed);
        checks++;
        if (oresp[p] !== er || odata[p] !== ed) begin
          errors++;
          $display("FAIL random port%0d cycle %0d: got resp=%0d data=%08h, want resp=%0d data=%08h",
                   p + 1, cyc, oresp[p], odata[p], er, ed);
        end
      end

      for (int p = 0; p < 4; p++) begin
        cmd_a[p] = ($urandom_range(0, 99) < 35) ? cmd_tab[$urandom_range(0, 11)] : 4'd0;
        case ($urandom_range(0, 3))
          0:       data_a[p] = $urandom_range(0, 20);
          1:       data_a[p] = 32'hFFFF_FFF0 | $urandom_range(0, 15);
          default: data_a[p] = $urandom;
        endcase
      end

      for (int p = 0; p < 4; p++) begin
        if (m_act[p] && !m_gnt[p] && m_cap[p] == cyc - 1) m_op2[p] = data_a[p];
      end

      winner = -1;
      for (int k = 1; k <= 4; k++) begin
`ifdef CALC1_ARB_FIXED_PRIO_EN
        cand = k - 1;
`else
        cand = (m_last + k) % 4;
`endif
        if (winner < 0 && m_act[cand] && !m_gnt[cand] && cyc >= m_cap[cand] + 2) winner = cand;
      end
      if (winner >= 0) begin
        m_gnt[winner] = 1'b1;
        m_due[winner] = cyc + ALU_STAGES;
        m_last        = winner;
      end

      for (int p = 0; p < 4; p++) begin
        if (!m_act[p] || (m_gnt[p] && m_due[p] == cyc)) begin
          m_act[p] = (cmd_a[p] != 4'd0);
          m_gnt[p] = 1'b0;
          m_cap[p] = cyc;
          m_cmd[p] = cmd_a[p];
          m_op1[p] = data_a[p];
        end
      end
      @(negedge c_clk);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_arith();
    test_shifts();
    test_round_robin();
`ifdef CALC1_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc1_arbiter.md
CALC1_ARBITER -- requirements
Module: calc1_arbiter

Interface
REQ-001 The block SHALL have parameter ALU_STAGES, default 1, setting the number of register stages in the shared ALU; legal values are 1..3.
REQ-002 c_clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 reqN_cmd_in  input  [0:3]  port N command, for N=1..4; 0=no-op, 1=add, 2=sub, 5=shift-left, 6=shift-right; all other values are invalid.
REQ-005 reqN_data_in  input  [0:31]  port N operand bus, for N=1..4; carries op1 in the command cycle and op2 in the following cycle.
REQ-006 out_dataN  output  [0:31]  port N result, for N=1..4; valid only when out_respN is non-zero.
REQ-007 out_respN  output  [0:1]  port N response, for N=1..4; 0=none, 1=success, 2=error (overflow, underflow or invalid command).

Function
REQ-008 Each port SHALL run its own FSM with states IDLE, OP2, WAIT and BUSY.
REQ-009 IDLE to OP2: cmd!=0 is sampled; the FSM latches cmd and op1.
REQ-010 OP2 to WAIT: on the next edge the FSM unconditionally latches op2 and ignores cmd.
REQ-011 WAIT to BUSY: the port is granted.
REQ-012 BUSY to IDLE: in the cycle the port's response is driven.
REQ-013 A non-zero cmd arriving while a port is not IDLE SHALL be ignored; it produces no response and leaves the port state unchanged.
REQ-014 The arbiter SHALL grant at most one WAIT port per cycle; the granted operation enters ALU stage 1 on that edge.
REQ-015 Default arbitration SHALL be round-robin: the search starts at the port after the last granted port and wraps 4 to 1; the pointer after reset selects port 1 first.
REQ-016 The ALU SHALL be fully pipelined and accept one operation per cycle; results carry their port tag through the pipeline.
REQ-017 Add: the result is op1+op2; a carry out of bit 0 SHALL give resp 2 with data 0.
REQ-018 Sub: the result is op1-op2; op2>op1 SHALL give resp 2 with data 0; op2==op1 SHALL give resp 1 with data 0.
REQ-019 Shifts: the shift amount is op2[27:31] (0..31); shifts are logical with zero fill and never raise an error.
REQ-020 Invalid commands SHALL consume a grant slot like a valid one and return resp 2 with data 0 at the normal latency.
REQ-021 Uncontended latency: for cmd sampled in cycle T, out_respN/out_dataN SHALL be driven during cycle T+2+ALU_STAGES for exactly one cycle.
REQ-022 Outside a response cycle, out_respN SHALL be 0 and out_dataN SHALL be 0.
REQ-023 Simultaneous WAIT on several ports SHALL be served in consecutive cycles in arbitration order with no idle cycle between grants; responses return in grant order.
REQ-024 A port MAY issue a new cmd in the cycle its response is driven.

Reset
REQ-025 Asserting reset SHALL immediately force all FSMs to IDLE, clear all latched operands, flush all ALU stages and tags, and reset the round-robin pointer.
REQ-026 During reset and on its release, all out_respN and out_dataN SHALL be 0.
REQ-027 Operations in flight when reset is asserted SHALL be discarded and never produce a response.
REQ-028 Commands present in the cycle reset deasserts SHALL be ignored; the first edge after deassertion is the earliest capture edge.

Configuration
REQ-029 With CALC1_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (port 1 > 2 > 3 > 4) and the round-robin pointer SHALL be omitted.
REQ-030 With CALC1_ARB_FIXED_PRIO_EN undefined, arbitration SHALL be round-robin per REQ-015.

Verification
REQ-031 Port1 add: op1=0000_0001h, op2=01FF_FFFFh -> out_resp1=1, out_data1=0200_0000h in cycle T+3 (ALU_STAGES=1); all other outputs 0.
REQ-032 Port2 add FFFF_FFFFh+1 -> resp 2, data 0; port3 sub 1-Fh -> resp 2, data 0; port4 cmd 3 -> resp 2, data 0.
REQ-033 All four ports issue add 1+1 in the same cycle; round-robin -> responses on ports 1,2,3,4 in consecutive cycles; repeating the burst -> order 2,3,4,1 is wrong, order restarts after the last grant (4), so 1,2,3,4 again; port 3 alone next -> granted immediately.
REQ-034 With CALC1_ARB_FIXED_PRIO_EN defined: port 1 issues back-to-back requests while port 4 waits -> port 4 is granted only in a cycle with no port-1 WAIT.
REQ-035 Shift-left of 1 by 0..31 and shift-right of 8000_0000h by 0..31 -> each result matches a single set bit, resp 1; amount op2=0000_0021h shifts by 1.
REQ-036 Reset asserted one cycle after a port-2 grant -> no response appears on any port; a post-reset add 2+3 on port 2 -> resp 1, data 5 at normal latency.
